// File: rtl/cdb_broadcast.sv
// cdb_broadcast: two-lane common data bus arbiter with one holding entry per FU.
// Define CDB_BYPASS_EN to let arrivals into empty holds compete in their arrival cycle.
module cdb_broadcast #(
    parameter int FU_NUM      = 5,
    parameter int PREG_NUMBER = 64,
    parameter int CDB_NUM     = 2,
    localparam int TAG_W      = $clog2(PREG_NUMBER),
    localparam int CNT_W      = $clog2(FU_NUM + 1)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [FU_NUM-1:0]        fu_done_i,
    input  logic [FU_NUM*TAG_W-1:0]  fu_tag_i,
    input  logic [FU_NUM*32-1:0]     fu_value_i,
    output logic [FU_NUM-1:0]        fu_ready_o,
    input  logic                     squash_i,
    output logic [CDB_NUM-1:0]       cdb_en_o,
    output logic [CDB_NUM*TAG_W-1:0] cdb_tag_o,
    output logic [CDB_NUM*32-1:0]    cdb_value_o,
    output logic [CNT_W-1:0]         pending_o
);

    localparam int PTR_W = (FU_NUM > 1) ? $clog2(FU_NUM) : 1;

    logic [FU_NUM-1:0]        hold_vld_q, hold_vld_d;
    logic [TAG_W-1:0]         hold_tag_q [FU_NUM];
    logic [TAG_W-1:0]         hold_tag_d [FU_NUM];
    logic [31:0]              hold_val_q [FU_NUM];
    logic [31:0]              hold_val_d [FU_NUM];
    logic [PTR_W-1:0]         rr_ptr_q, rr_ptr_d;
    logic [CDB_NUM-1:0]       cdb_en_q, cdb_en_d;
    logic [CDB_NUM*TAG_W-1:0] cdb_tag_q, cdb_tag_d;
    logic [CDB_NUM*32-1:0]    cdb_val_q, cdb_val_d;

    logic [FU_NUM-1:0]        cand;
    logic [FU_NUM-1:0]        grant;
    logic [FU_NUM-1:0]        ready;
    logic [FU_NUM-1:0]        xfer;
    logic [TAG_W-1:0]         cand_tag [FU_NUM];
    logic [31:0]              cand_val [FU_NUM];
    logic                     g0_vld, g1_vld;
    logic [PTR_W-1:0]         g0_idx, g1_idx, scan_idx;
    logic [CNT_W-1:0]         pend;

    function automatic logic [PTR_W-1:0] wrap_idx(
        input logic [PTR_W-1:0] base,
        input int               off
    );
        int s;
        s = int'(base) + off;
        if (s >= FU_NUM) s = s - FU_NUM;
        return PTR_W'(s);
    endfunction

    // A valid hold always wins over a fresh arrival from the same FU.
    always_comb begin
        for (int i = 0; i < FU_NUM; i++) begin
`ifdef CDB_BYPASS_EN
            cand[i] = (hold_vld_q[i] | fu_done_i[i]) & ~squash_i & ~reset;
`else
            cand[i] = hold_vld_q[i] & ~squash_i & ~reset;
`endif
            cand_tag[i] = hold_vld_q[i] ? hold_tag_q[i]
                                        : fu_tag_i[i*TAG_W +: TAG_W];
            cand_val[i] = hold_vld_q[i] ? hold_val_q[i]
                                        : fu_value_i[i*32 +: 32];
        end
    end

    always_comb begin
        g0_vld   = 1'b0;
        g1_vld   = 1'b0;
        g0_idx   = '0;
        g1_idx   = '0;
        scan_idx = '0;
        for (int k = 0; k < FU_NUM; k++) begin
            scan_idx = wrap_idx(rr_ptr_q, k);
            if (cand[scan_idx]) begin
                if (!g0_vld) begin
                    g0_vld = 1'b1;
                    g0_idx = scan_idx;
                end else if (!g1_vld) begin
                    g1_vld = 1'b1;
                    g1_idx = scan_idx;
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < FU_NUM; i++) begin
            grant[i] = (g0_vld && (g0_idx == PTR_W'(i)))
                    || (g1_vld && (g1_idx == PTR_W'(i)));
            ready[i] = ~reset & ~squash_i & (~hold_vld_q[i] | grant[i]);
        end
        xfer = fu_done_i & ready;
    end

    assign fu_ready_o = ready;

    // A granted arrival into an empty hold went straight to the bus.
    always_comb begin
        hold_vld_d = hold_vld_q;
        hold_tag_d = hold_tag_q;
        hold_val_d = hold_val_q;
        for (int i = 0; i < FU_NUM; i++) begin
            if (squash_i) begin
                hold_vld_d[i] = 1'b0;
            end else if (xfer[i] && !(grant[i] && !hold_vld_q[i])) begin
                hold_vld_d[i] = 1'b1;
                hold_tag_d[i] = fu_tag_i[i*TAG_W +: TAG_W];
                hold_val_d[i] = fu_value_i[i*32 +: 32];
            end else if (grant[i]) begin
                hold_vld_d[i] = 1'b0;
            end
        end
    end

    always_comb begin
        cdb_en_d  = '0;
        cdb_tag_d = '0;
        cdb_val_d = '0;
        if (g0_vld) begin
            cdb_en_d[0]            = 1'b1;
            cdb_tag_d[0 +: TAG_W]  = cand_tag[g0_idx];
            cdb_val_d[0 +: 32]     = cand_val[g0_idx];
        end
        if (g1_vld) begin
            cdb_en_d[1]            = 1'b1;
            cdb_tag_d[TAG_W +: TAG_W] = cand_tag[g1_idx];
            cdb_val_d[32 +: 32]    = cand_val[g1_idx];
        end
    end

    always_comb begin
        if (g1_vld)      rr_ptr_d = wrap_idx(g1_idx, 1);
        else if (g0_vld) rr_ptr_d = wrap_idx(g0_idx, 1);
        else             rr_ptr_d = rr_ptr_q;
    end

    always_comb begin
        pend = '0;
        for (int i = 0; i < FU_NUM; i++) begin
            pend = pend + CNT_W'(hold_vld_q[i]);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            hold_vld_q <= '0;
            rr_ptr_q   <= '0;
            cdb_en_q   <= '0;
            cdb_tag_q  <= '0;
            cdb_val_q  <= '0;
            for (int i = 0; i < FU_NUM; i++) begin
                hold_tag_q[i] <= '0;
                hold_val_q[i] <= '0;
            end
        end else begin
            hold_vld_q <= hold_vld_d;
            hold_tag_q <= hold_tag_d;
            hold_val_q <= hold_val_d;
            rr_ptr_q   <= rr_ptr_d;
            cdb_en_q   <= cdb_en_d;
            cdb_tag_q  <= cdb_tag_d;
            cdb_val_q  <= cdb_val_d;
        end
    end

    assign cdb_en_o    = cdb_en_q;
    assign cdb_tag_o   = cdb_tag_q;
    assign cdb_value_o = cdb_val_q;
    assign pending_o   = pend;

endmodule

// File: tb/tb_cdb_broadcast.sv
// tb_cdb_broadcast: directed checks of arbitration order, latency, squash and reset.
// Expected latencies follow CDB_BYPASS_EN when it is defined for the build.
module tb_cdb_broadcast;

    localparam int FU = 5;
    localparam int TW = 6;
`ifdef CDB_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic            clock = 1'b0;
    logic            reset;
    logic [FU-1:0]   fu_done;
    logic [FU*TW-1:0] fu_tag;
    logic [FU*32-1:0] fu_val;
    logic [FU-1:0]   fu_ready;
    logic            squash;
    logic [1:0]      cdb_en;
    logic [2*TW-1:0] cdb_tag;
    logic [63:0]     cdb_val;
    logic [2:0]      pending;

    int n_checks = 0;
    int n_fail   = 0;

    cdb_broadcast dut (
        .clock       (clock),
        .reset       (reset),
        .fu_done_i   (fu_done),
        .fu_tag_i    (fu_tag),
        .fu_value_i  (fu_val),
        .fu_ready_o  (fu_ready),
        .squash_i    (squash),
        .cdb_en_o    (cdb_en),
        .cdb_tag_o   (cdb_tag),
        .cdb_value_o (cdb_val),
        .pending_o   (pending)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        fu_done = '0;
        fu_tag  = '0;
        fu_val  = '0;
        squash  = 1'b0;
    endtask

    task automatic put(input int i, input logic [TW-1:0] t,
                       input logic [31:0] v);
        fu_done[i]         = 1'b1;
        fu_tag[i*TW +: TW] = t;
        fu_val[i*32 +: 32] = v;
    endtask

    initial begin
        // reset with a completion present: it must be dropped
        reset = 1'b1;
        idle();
        put(0, 6'd5, 32'h55);
        #1;
        chk("rst_ready", fu_ready, 5'b00000);
        tick();
        tick();
        chk("rst_en", cdb_en, 2'b00);
        chk("rst_tag", cdb_tag, 12'h000);
        chk("rst_val", cdb_val, 64'h0);
        reset = 1'b0;
        idle();
        #1;
        chk("idle_ready", fu_ready, 5'b11111);
        chk("idle_en", cdb_en, 2'b00);
        chk("idle_pend", pending, 3'd0);

        // single completion latency
        put(1, 6'd7, 32'hAB);
        #1;
        chk("t2_ready", fu_ready, 5'b11111);
        tick();
        idle();
`ifndef CDB_BYPASS_EN
        chk("t2_en_early", cdb_en, 2'b00);
        chk("t2_pend_held", pending, 3'd1);
        tick();
`endif
        chk("t2_en", cdb_en, 2'b01);
        chk("t2_tag", cdb_tag, {6'd0, 6'd7});
        chk("t2_val", cdb_val, {32'h0, 32'hAB});
        chk("t2_pend", pending, 3'd0);
        tick();
        chk("t2_en_after", cdb_en, 2'b00);

        // all FUs at once from rr_ptr = 0
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < FU; i++) put(i, TW'(i + 1), 32'h100 + i + 1);
        tick();
        idle();
`ifndef CDB_BYPASS_EN
        chk("t3_pend5", pending, 3'd5);
        chk("t3_en0", cdb_en, 2'b00);
        chk("t3_ready_full", fu_ready, 5'b00011);
        tick();
`else
        chk("t3_ready_byp", fu_ready, 5'b01111);
`endif
        chk("t3_en_a", cdb_en, 2'b11);
        chk("t3_tag_a", cdb_tag, {6'd2, 6'd1});
        chk("t3_val_a", cdb_val, {32'h102, 32'h101});
        chk("t3_pend3", pending, 3'd3);
        tick();
        chk("t3_en_b", cdb_en, 2'b11);
        chk("t3_tag_b", cdb_tag, {6'd4, 6'd3});
        chk("t3_pend1", pending, 3'd1);
        tick();
        chk("t3_en_c", cdb_en, 2'b01);
        chk("t3_tag_c", cdb_tag, {6'd0, 6'd5});
        chk("t3_val_c", cdb_val, {32'h0, 32'h105});
        chk("t3_pend0", pending, 3'd0);

        // wrap: move rr_ptr to 4, then FU4 must lead FU0
        put(3, 6'd10, 32'h10);
        tick();
        idle();
        repeat (LAT - 1) tick();
        chk("t4_en_fu3", cdb_en, 2'b01);
        chk("t4_tag_fu3", cdb_tag, {6'd0, 6'd10});
        put(0, 6'd11, 32'h11);
        put(4, 6'd12, 32'h12);
        tick();
        idle();
        repeat (LAT - 1) tick();
        chk("t4_en_wrap", cdb_en, 2'b11);
        chk("t4_tag_wrap", cdb_tag, {6'd11, 6'd12});
        chk("t4_val_wrap", cdb_val, {32'h11, 32'h12});
        // rr_ptr is now 1, so FU1 leads FU0
        put(0, 6'd13, 32'h13);
        put(1, 6'd14, 32'h14);
        tick();
        idle();
        repeat (LAT - 1) tick();
        chk("t4_tag_rr1", cdb_tag, {6'd13, 6'd14});

        // squash with holds pending and an FU0 completion offered
        put(2, 6'd16, 32'h16);
        put(3, 6'd17, 32'h17);
        tick();
        idle();
`ifndef CDB_BYPASS_EN
        chk("t5_pend2", pending, 3'd2);
`endif
        squash = 1'b1;
        put(0, 6'd18, 32'h18);
        #1;
        chk("t5_ready_sq", fu_ready, 5'b00000);
        tick();
        idle();
        chk("t5_en_sq", cdb_en, 2'b00);
        chk("t5_tag_sq", cdb_tag, 12'h000);
        chk("t5_pend_sq", pending, 3'd0);
        tick();
        chk("t5_en_drop", cdb_en, 2'b00);
        chk("t5_pend_drop", pending, 3'd0);

        // granted hold refilled in the same cycle
        put(0, 6'd21, 32'h21);
        put(1, 6'd22, 32'h22);
        put(2, 6'd20, 32'h20);
        tick();
        idle();
`ifndef CDB_BYPASS_EN
        put(2, 6'd9, 32'h9);
        #1;
        chk("t6_ready", fu_ready, 5'b11110);
        tick();
        idle();
        chk("t6_en_a", cdb_en, 2'b11);
        chk("t6_tag_a", cdb_tag, {6'd20, 6'd22});
        chk("t6_pend_a", pending, 3'd2);
        tick();
        chk("t6_en_b", cdb_en, 2'b11);
        chk("t6_tag_b", cdb_tag, {6'd9, 6'd21});
        chk("t6_val_b", cdb_val, {32'h9, 32'h21});
        chk("t6_pend_b", pending, 3'd0);
`else
        chk("t6_en_a", cdb_en, 2'b11);
        chk("t6_tag_a", cdb_tag, {6'd22, 6'd21});
        chk("t6_pend_a", pending, 3'd1);
        put(2, 6'd9, 32'h9);
        #1;
        chk("t6_ready", fu_ready, 5'b11111);
        tick();
        idle();
        chk("t6_en_b", cdb_en, 2'b01);
        chk("t6_tag_b", cdb_tag, {6'd0, 6'd20});
        chk("t6_pend_b", pending, 3'd1);
        tick();
        chk("t6_en_c", cdb_en, 2'b01);
        chk("t6_tag_c", cdb_tag, {6'd0, 6'd9});
        chk("t6_val_c", cdb_val, {32'h0, 32'h9});
        chk("t6_pend_c", pending, 3'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cdb_broadcast.md
CDB_BROADCAST -- requirements
Module: cdb_broadcast

Interface
REQ-001 The block SHALL have parameter FU_NUM, default 5, number of functional units feeding completions.
REQ-002 The block SHALL have parameter PREG_NUMBER, default 64, physical register count; TAG_W = $clog2(PREG_NUMBER).
REQ-003 The block SHALL have parameter CDB_NUM, fixed at 2, broadcast lanes per cycle.
REQ-004 clock  input  1  rising-edge clock.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 fu_done_i  input  FU_NUM  per-FU completion valid.
REQ-007 fu_tag_i  input  FU_NUM*TAG_W  per-FU destination physical tag.
REQ-008 fu_value_i  input  FU_NUM*32  per-FU result value.
REQ-009 fu_ready_o  output  FU_NUM  per-FU acceptance; completion transfers when fu_done_i[i] && fu_ready_o[i].
REQ-010 squash_i  input  1  branch recovery; discard all pending completions.
REQ-011 cdb_en_o  output  2  registered lane valid, lane 0 filled first.
REQ-012 cdb_tag_o  output  2*TAG_W  registered broadcast tags.
REQ-013 cdb_value_o  output  2*32  registered broadcast values.
REQ-014 pending_o  output  $clog2(FU_NUM+1)  count of valid holding entries.

Function
REQ-015 The block SHALL hold one entry (valid, tag, value) per FU.
REQ-016 fu_ready_o[i] SHALL be combinationally high when hold[i] is empty or hold[i] is granted this cycle, and low otherwise or while squash_i is high.
REQ-017 Arbitration SHALL scan candidates round-robin from rr_ptr (wrapping at FU_NUM-1 -> 0), granting the first two valid candidates, the first to lane 0 and the second to lane 1.
REQ-018 After any grant, rr_ptr SHALL become (index of last granted FU + 1) mod FU_NUM; with no grant, rr_ptr SHALL hold.
REQ-019 Granted entries SHALL load cdb_en_o/cdb_tag_o/cdb_value_o at the next edge; ungranted lanes SHALL load en=0, tag=0, value=0.
REQ-020 A granted hold entry SHALL clear at the edge, unless a new completion transfers into it on the same cycle, in which case it SHALL load the new completion.
REQ-021 Without bypass, a completion transferred in cycle T SHALL appear on the CDB no earlier than cycle T+2.
REQ-022 With all FU_NUM holds full and no grants, all fu_ready_o SHALL be low and the holds SHALL be unchanged.
REQ-023 With squash_i high, at the next edge all holds SHALL clear, cdb_en_o SHALL become 0, rr_ptr SHALL hold, and no completion SHALL transfer.
REQ-024 pending_o SHALL equal the population count of hold valid bits in the current cycle.

Reset
REQ-025 On reset, all holds SHALL be invalid, rr_ptr = 0, and cdb_en_o, cdb_tag_o and cdb_value_o SHALL be 0.
REQ-026 Reset SHALL take priority over squash_i and fu_done_i; completions present during reset SHALL be dropped.
REQ-027 While reset is high, fu_ready_o SHALL be all zero.

Configuration
REQ-028 Macro CDB_BYPASS_EN SHALL control same-cycle bypass.
REQ-029 With CDB_BYPASS_EN defined, an incoming fu_done_i[i] whose hold[i] is empty SHALL be an arbitration candidate in its arrival cycle; if granted, it SHALL NOT be stored, and its latency SHALL be T+1.
REQ-030 Without CDB_BYPASS_EN, only hold entries SHALL be candidates (latency per REQ-021).

Verification
REQ-031 Reset, then no done -> cdb_en_o=00, fu_ready_o=11111, pending_o=0.
REQ-032 FU1 done with tag 7, value 0xAB in cycle 1 -> cdb_en_o=01, tag 7, value 0xAB in cycle 3 (cycle 2 with CDB_BYPASS_EN).
REQ-033 All 5 FUs done in one cycle with tags 1..5, rr_ptr=0 -> broadcasts {1,2}, then {3,4}, then {5}, one pair per cycle; pending_o 5,3,1,0.
REQ-034 rr_ptr=4, holds 0 and 4 valid -> lane0=FU4, lane1=FU0; rr_ptr becomes 1.
REQ-035 Holds 2 and 3 valid, squash_i high with FU0 done -> next cycle cdb_en_o=00, pending_o=0, FU0 completion dropped.
REQ-036 FU2 hold granted while FU2 presents new done with tag 9 -> fu_ready_o[2]=1, tag 9 stored, then broadcast on a later cycle.
